// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the 5-stage RISC-V core.
package pipeline_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;

  // addi x0, x0, 0 -- canonical bubble instruction
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [0:0] {
    StBoot,
    StRun
  } fetch_state_e;

  // Pipeline-register bundle at the default XLEN
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [31:0]             instr;
    logic                    valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register {pc, instr, valid} with write-enable and flush.
// Flush wins over write-enable and loads a bubble. The same block also serves as ID/EX.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            write_en_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  input  logic            valid_i,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_d, pc_q;
  logic [31:0]     instr_d, instr_q;
  logic            valid_d, valid_q;

  // Next-state: bubble on flush, load on write-enable, otherwise hold
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush_i) begin
      pc_d    = '0;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (write_en_i) begin
      pc_d    = pc_i;
      instr_d = instr_i;
      valid_d = valid_i;
    end
  end

  // State register, asynchronous reset to a bubble
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, boot FSM, IF/ID register and saturating
// stall/flush debug counters.
module if_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned    XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned    CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_write_en,
  input  logic             ifid_write_en,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [XLEN-1:0]  if_id_pc,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [XLEN-1:0]  PcStep    = XLEN'(4);
  localparam logic [XLEN-1:0]  AlignMask = ~XLEN'(3);
  localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  fetch_state_e     state_d, state_q;
  logic [XLEN-1:0]  pc_d, pc_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

  logic boot;
  logic flush;
  logic stall;

  // Decode this cycle's action; BOOT ignores redirect and hazard inputs
  always_comb begin
    boot  = (state_q == StBoot);
    flush = !boot && branch_taken;
    // A branch is older than any ID hazard, so a simultaneous stall is dropped
    stall = !boot && !branch_taken && (!pc_write_en || !ifid_write_en);
  end

  // FSM next-state: BOOT lasts exactly one edge after reset release
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StBoot;
    endcase
  end

  // PC next-state: redirect, advance or hold; +4 wraps silently
  always_comb begin
    pc_d = pc_q;
    if (boot) begin
      pc_d = RESET_PC;
    end else if (flush) begin
      pc_d = branch_target & AlignMask;
    end else if (pc_write_en) begin
      pc_d = pc_q + PcStep;
    end
  end

  // Saturating debug counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
    if (flush && (flush_cnt_q != CntMax)) begin
      flush_cnt_d = flush_cnt_q + CntOne;
    end
  end

  // State, PC and counter registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StBoot;
      pc_q        <= RESET_PC;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // BOOT reuses the flush path so IF/ID stays a bubble
  if_id_reg #(
    .XLEN(XLEN)
  ) u_if_id_reg (
    .clk_i      (clk),
    .rst_i      (reset),
    .flush_i    (boot || flush),
    .write_en_i (ifid_write_en),
    .pc_i       (pc_q),
    .instr_i    (imem_rdata),
    .valid_i    (1'b1),
    .pc_o       (if_id_pc),
    .instr_o    (if_id_instr),
    .valid_o    (if_id_valid)
  );

  assign imem_addr   = pc_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule
